// File: rtl/text_console_pkg.sv
// rtl/text_console_pkg.sv - shared geometry, ASCII codes, FSM states and cell addressing
// Character-cell console constants and the logical-to-physical address helper.
package text_console_pkg;

  localparam int COLS   = 160;
  localparam int ROWS   = 50;
  localparam int ADDR_W = 13;
  localparam int COL_W  = 8;
  localparam int ROW_W  = 6;
  localparam int CELLS  = COLS * ROWS;

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  localparam logic [7:0] SP       = 8'h20;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] BS       = 8'h08;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_ROW
  } state_t;

  // prow*160 is built as prow*128 + prow*32 so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [ROW_W-1:0] top,
                                                  input logic [COL_W-1:0] col);
    logic [ROW_W:0]   sum;
    logic [ROW_W-1:0] prow;
    sum  = {1'b0, row} + {1'b0, top};
    prow = (sum >= 7'(ROWS)) ? ROW_W'(sum - 7'(ROWS)) : sum[ROW_W-1:0];
    return {prow, 7'b0} + {2'b0, prow, 5'b0} + {5'b0, col};
  endfunction

endpackage

// File: rtl/text_console_if.sv
// rtl/text_console_if.sv - byte stream, renderer read port and cursor/status bundle
// The master side is the byte source plus renderer; the slave side is the console engine.
interface text_console_if;

  logic                             in_valid;
  logic [7:0]                       in_data;
  logic                             in_ready;
  logic [text_console_pkg::COL_W-1:0] rd_col;
  logic [text_console_pkg::ROW_W-1:0] rd_row;
  logic [7:0]                       rd_data;
  logic [text_console_pkg::COL_W-1:0] cursor_col;
  logic [text_console_pkg::ROW_W-1:0] cursor_row;
  logic                             busy;

  modport master (
    output in_valid, in_data, rd_col, rd_row,
    input  in_ready, rd_data, cursor_col, cursor_row, busy
  );

  modport slave (
    input  in_valid, in_data, rd_col, rd_row,
    output in_ready, rd_data, cursor_col, cursor_row, busy
  );

endinterface

// File: rtl/text_console_char_ram.sv
// rtl/text_console_char_ram.sv - simple dual-port character RAM, read-first registered read
// No reset on storage or read register so the array maps onto block RAM.
module text_console_char_ram
  import text_console_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [0:(1 << ADDR_W) - 1];
  logic [7:0] rdata_q;

  // Read and write in the same block: a colliding read sees the old contents.
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/text_console.sv
// rtl/text_console.sv - text buffer and cursor engine with circular-offset hardware scroll
// Owns the clear/idle FSM, cursor, top-row offset and all RAM address arithmetic.
module text_console
  import text_console_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  text_console_if.slave  con
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  clr_q, clr_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ROW_W-1:0]   top_q, top_d;
  logic               oob_q, oob_d;

  logic               accept;
  logic               newline;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr;
  logic [7:0]         ram_wdata;
  logic [ADDR_W-1:0]  ram_raddr;
  logic [7:0]         ram_rdata;

  assign accept = con.in_valid && (state_q == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR_ALL;
      clr_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      top_q   <= '0;
      oob_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      top_q   <= top_d;
      oob_q   <= oob_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    col_d     = col_q;
    row_d     = row_q;
    top_d     = top_q;
    newline   = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = cell_addr(row_q, top_q, col_q);
    ram_wdata = SP;

    case (state_q)
      CLEAR_ALL: begin
        ram_we    = 1'b1;
        ram_waddr = clr_q;
        if (clr_q == LAST_CELL) begin
          clr_d   = '0;
          state_d = IDLE;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end

      // Cursor sits on the last logical row, which after the offset bump is the old top row.
      CLEAR_ROW: begin
        ram_we    = 1'b1;
        ram_waddr = cell_addr(row_q, top_q, COL_W'(clr_q));
        if (clr_q == ADDR_W'(COLS - 1)) begin
          clr_d   = '0;
          state_d = IDLE;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end

      IDLE: begin
        if (accept) begin
          if (con.in_data >= PRINT_LO && con.in_data <= PRINT_HI) begin
            ram_we    = 1'b1;
            ram_wdata = con.in_data;
            if (col_q < LAST_COL) begin
              col_d = col_q + 1'b1;
            end else begin
              col_d   = '0;
              newline = 1'b1;
            end
          end else if (con.in_data == LF) begin
            col_d   = '0;
            newline = 1'b1;
          end else if (con.in_data == CR) begin
            col_d = '0;
          end else if (con.in_data == BS) begin
            if (col_q != '0) begin
              col_d     = col_q - 1'b1;
              ram_we    = 1'b1;
              ram_waddr = cell_addr(row_q, top_q, col_q - 1'b1);
            end
          end
        end
      end

      default: begin
        state_d = CLEAR_ALL;
        clr_d   = '0;
      end
    endcase

    if (newline) begin
      if (row_q < LAST_ROW) begin
        row_d = row_q + 1'b1;
      end else begin
        top_d   = (top_q == LAST_ROW) ? '0 : top_q + 1'b1;
        clr_d   = '0;
        state_d = CLEAR_ROW;
      end
    end

    oob_d     = (con.rd_col >= COL_W'(COLS)) || (con.rd_row >= ROW_W'(ROWS));
    ram_raddr = cell_addr(con.rd_row, top_q, con.rd_col);
  end

  text_console_char_ram u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign con.rd_data    = oob_q ? SP : ram_rdata;
  assign con.in_ready   = (state_q == IDLE);
  assign con.busy       = (state_q != IDLE);
  assign con.cursor_col = col_q;
  assign con.cursor_row = row_q;

endmodule

// File: tb/tb_text_console.sv
// tb/tb_text_console.sv - randomized bench against a shifting-screen reference model
// The model keeps the screen as a logical 2-D array and physically shifts rows on scroll.
module tb_text_console;
  import text_console_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  text_console_if con();

  text_console dut (
    .clk   (clk),
    .reset (reset),
    .con   (con)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] scr [ROWS][COLS];
  int mc, mr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        scr[r][c] = SP;
    mc = 0;
    mr = 0;
  endtask

  task automatic model_newline();
    if (mr < ROWS - 1) begin
      mr++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++)
          scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++)
        scr[ROWS-1][c] = SP;
    end
  endtask

  task automatic model_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[mr][mc] = b;
      if (mc < COLS - 1) mc++;
      else begin
        mc = 0;
        model_newline();
      end
    end else if (b == 8'h0A) begin
      mc = 0;
      model_newline();
    end else if (b == 8'h0D) begin
      mc = 0;
    end else if (b == 8'h08 && mc > 0) begin
      mc--;
      scr[mr][mc] = SP;
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!con.in_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq("ready_wait", con.in_ready, 1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready();
    con.in_valid = 1'b1;
    con.in_data  = b;
    @(posedge clk);
    #1;
    con.in_valid = 1'b0;
    model_apply(b);
    @(negedge clk);
  endtask

  task automatic check_cursor(input string tag);
    check_eq({tag, "_col"}, con.cursor_col, mc);
    check_eq({tag, "_row"}, con.cursor_row, mr);
  endtask

  task automatic probe(input string tag, input int c, input int r);
    logic [7:0] exp;
    wait_ready();
    con.rd_col = c[7:0];
    con.rd_row = r[5:0];
    @(negedge clk);
    exp = (c >= COLS || r >= ROWS) ? SP : scr[r][c];
    check_eq(tag, con.rd_data, exp);
  endtask

  task automatic sweep(input string tag);
    int errs;
    errs = 0;
    con.rd_col = 8'd0;
    con.rd_row = 6'd0;
    for (int i = 0; i < CELLS; i++) begin
      @(negedge clk);
      if (con.rd_data !== scr[i / COLS][i % COLS]) errs++;
      if (i + 1 < CELLS) begin
        con.rd_col = 8'((i + 1) % COLS);
        con.rd_row = 6'((i + 1) / COLS);
      end
    end
    check_eq(tag, errs, 0);
  endtask

  task automatic count_clear(input string tag);
    int cnt;
    cnt = 0;
    while (!con.in_ready && cnt < 20000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_eq(tag, cnt, CELLS);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    int pick, lowcnt;

    con.in_valid = 1'b0;
    con.in_data  = 8'h00;
    con.rd_col   = 8'd0;
    con.rd_row   = 6'd0;
    model_clear();

    repeat (3) @(negedge clk);
    check_eq("rst_ready", con.in_ready, 0);
    check_eq("rst_busy", con.busy, 1);
    check_eq("rst_ccol", con.cursor_col, 0);
    check_eq("rst_crow", con.cursor_row, 0);
    check_eq("rst_rdata", con.rd_data, 8'h20);

    reset = 1'b0;
    count_clear("clear_len");
    sweep("sweep_clear");
    probe("oob_col", 200, 3);
    probe("oob_row", 5, 55);

    // Same-cycle write and read of (0,0): old value first, new value one cycle later.
    con.rd_col   = 8'd0;
    con.rd_row   = 6'd0;
    con.in_valid = 1'b1;
    con.in_data  = 8'h5A;
    @(posedge clk);
    #1;
    con.in_valid = 1'b0;
    model_apply(8'h5A);
    @(negedge clk);
    check_eq("collide_old", con.rd_data, 8'h20);
    @(negedge clk);
    check_eq("collide_new", con.rd_data, 8'h5A);

    send(8'h0D);
    check_cursor("cr");
    send(8'h48); send(8'h4F); send(8'h4C); send(8'h41);
    check_eq("hola_col", con.cursor_col, 4);
    check_eq("hola_row", con.cursor_row, 0);
    probe("hola_0", 0, 0);
    check_eq("hola_h", con.rd_data, 8'h48);
    probe("hola_1", 1, 0);
    check_eq("hola_o", con.rd_data, 8'h4F);
    probe("hola_2", 2, 0);
    check_eq("hola_l", con.rd_data, 8'h4C);
    probe("hola_3", 3, 0);
    check_eq("hola_a", con.rd_data, 8'h41);

    send(8'h0D);
    for (int i = 0; i < COLS + 1; i++) send(8'h41);
    check_eq("wrap_col", con.cursor_col, 1);
    check_eq("wrap_row", con.cursor_row, 1);
    probe("wrap_r0c159", COLS - 1, 0);
    check_eq("wrap_last", con.rd_data, 8'h41);
    probe("wrap_r1c0", 0, 1);
    send(8'h08);
    check_eq("bs1_col", con.cursor_col, 0);
    check_eq("bs1_row", con.cursor_row, 1);
    probe("bs_cleared", 0, 1);
    check_eq("bs_space", con.rd_data, 8'h20);
    send(8'h08);
    check_eq("bs2_col", con.cursor_col, 0);
    check_eq("bs2_row", con.cursor_row, 1);
    probe("bs_noop_prev", COLS - 1, 0);

    while (mr < ROWS - 1) send(8'h0A);
    send(8'h58);
    send(8'h0A);
    check_eq("scroll_busy", con.busy, 1);
    lowcnt = 0;
    while (!con.in_ready && lowcnt < 1000) begin
      lowcnt++;
      @(negedge clk);
    end
    check_eq("scroll_low", lowcnt, COLS);
    check_eq("scroll_col", con.cursor_col, 0);
    check_eq("scroll_row", con.cursor_row, ROWS - 1);
    probe("scroll_x", 0, ROWS - 2);
    check_eq("scroll_xv", con.rd_data, 8'h58);
    sweep("sweep_scroll");

    for (int i = 0; i < 300; i++) begin
      pick = $urandom_range(0, 99);
      if (pick < 55)      b = 8'($urandom_range(32'h20, 32'h7E));
      else if (pick < 70) b = 8'h0A;
      else if (pick < 78) b = 8'h0D;
      else if (pick < 90) b = 8'h08;
      else if (pick < 95) b = 8'($urandom_range(32'h7F, 32'hFF));
      else                b = 8'($urandom_range(32'h00, 32'h07));
      send(b);
      check_cursor("rnd");
      if ($urandom_range(0, 3) == 0)
        probe("rnd_rd", int'($urandom_range(0, 170)), int'($urandom_range(0, 52)));
    end
    wait_ready();
    sweep("sweep_random");

    while (mr < ROWS - 1) send(8'h0A);
    send(8'h0A);
    repeat (20) @(negedge clk);
    check_eq("mid_busy", con.busy, 1);
    reset = 1'b1;
    #1;
    check_eq("rst2_ready", con.in_ready, 0);
    check_eq("rst2_busy", con.busy, 1);
    check_eq("rst2_ccol", con.cursor_col, 0);
    check_eq("rst2_crow", con.cursor_row, 0);
    check_eq("rst2_rdata", con.rd_data, 8'h20);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    count_clear("clear2_len");
    sweep("sweep_clear2");
    send(8'h51);
    check_cursor("post_rst");
    probe("post_rst_q", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
